// File: rtl/adc_scan_scheduler.sv
// adc_scan_scheduler: owns the SPI master in front of the SMPS ADC.
// Resets the master, writes the range and control registers, then runs
// periodic conversion scans over the channels selected by ch_mask and
// publishes each result with its channel tag.
// Optional build macro: ADC_OVERSAMPLE_EN (4 conversions per channel,
// averaged through a 14-bit accumulator).
module adc_scan_scheduler #(
  parameter int          NUM_CH     = 4,
  parameter int          CH_W       = 2,
  parameter int          PERIOD     = 1000,
  parameter int          CNT_W      = 16,
  parameter logic [15:0] RANGE_WORD = 16'hD555,
  parameter logic [15:0] CNTRL_WORD = 16'h8310,
  parameter logic [15:0] CONV_BASE  = 16'h8310
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              overrun_clr,
  output logic              m_enable,
  output logic              m_rst_n,
  input  logic              m_busy,
  output logic [15:0]       m_tx_data,
  input  logic [15:0]       m_rx_data,
  output logic [11:0]       res_data,
  output logic [CH_W-1:0]   res_ch,
  output logic              res_valid,
  output logic              scan_done,
  output logic              init_done,
  output logic              overrun
);

  typedef enum logic [3:0] {
    SPI_RST, INIT_RNG, RNG_WAIT, INIT_CTL, CTL_WAIT,
    IDLE, SELECT, XFER, XFER_WAIT, STORE
  } state_t;

  state_t            state, state_nx;
  logic [NUM_CH-1:0] pending;
  logic [NUM_CH-1:0] cur_bit;
  logic [NUM_CH-1:0] pending_clr;
  logic [CH_W-1:0]   cur_ch;
  logic [CH_W-1:0]   sel_ch;
  logic [15:0]       conv_word;
  logic [CNT_W-1:0]  cnt;
  logic              tick;
  logic              skip;
  logic              xfer_done;
  logic              scan_start;
  logic              cap_last;
  logic              unused_rx;

  // Upper status nibble of the ADC response carries nothing we need.
  assign unused_rx = ^m_rx_data[15:12];

`ifdef ADC_OVERSAMPLE_EN
  logic [13:0] acc;
  logic [13:0] acc_sum;
  logic [1:0]  os_cnt;
  assign acc_sum  = acc + {2'b00, m_rx_data[11:0]};
  assign cap_last = (os_cnt == 2'd3);
`else
  assign cap_last = 1'b1;
`endif

  // The master needs a cycle to raise busy, so the first wait cycle is ignored.
  assign xfer_done   = !skip && !m_busy;
  assign tick        = init_done && run && (cnt == CNT_W'(PERIOD - 1));
  assign scan_start  = tick && run && (|ch_mask);
  assign cur_bit     = {{(NUM_CH-1){1'b0}}, 1'b1} << cur_ch;
  assign pending_clr = pending & ~cur_bit;
  assign conv_word   = CONV_BASE | ({{(16-CH_W){1'b0}}, sel_ch} << 10);

  // Lowest set bit of the pending mask picks the next channel.
  always_comb begin
    sel_ch = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (pending[i]) sel_ch = CH_W'(i);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= SPI_RST;
    else     state <= state_nx;
  end

  // Next-state logic and Moore decodes for the master handshake.
  always_comb begin
    state_nx = state;
    m_enable = 1'b0;
    m_rst_n  = 1'b1;
    case (state)
      SPI_RST: begin
        m_rst_n  = 1'b0;
        state_nx = INIT_RNG;
      end
      INIT_RNG: begin
        m_enable = 1'b1;
        state_nx = RNG_WAIT;
      end
      RNG_WAIT:  if (xfer_done) state_nx = INIT_CTL;
      INIT_CTL: begin
        m_enable = 1'b1;
        state_nx = CTL_WAIT;
      end
      CTL_WAIT:  if (xfer_done) state_nx = IDLE;
      IDLE:      if (scan_start) state_nx = SELECT;
      SELECT:    state_nx = XFER;
      XFER: begin
        m_enable = 1'b1;
        state_nx = XFER_WAIT;
      end
      XFER_WAIT: if (xfer_done) state_nx = cap_last ? STORE : XFER;
      STORE:     state_nx = (|pending_clr) ? SELECT : IDLE;
      default:   state_nx = SPI_RST;
    endcase
  end

  // Arm the first-cycle busy ignore right after every start pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) skip <= 1'b0;
    else     skip <= m_enable;
  end

  // Scan period counter; held at zero until configured and while stopped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               cnt <= '0;
    else if (!init_done || !run)           cnt <= '0;
    else if (cnt == CNT_W'(PERIOD - 1))    cnt <= '0;
    else                                   cnt <= cnt + 1'b1;
  end

  // Sticky overrun: a tick that finds the scheduler busy is dropped. Set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          overrun <= 1'b0;
    else if (tick && state != IDLE)   overrun <= 1'b1;
    else if (overrun_clr)             overrun <= 1'b0;
  end

  // Datapath: tx word, scan bookkeeping and registered result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_tx_data <= '0;
      pending   <= '0;
      cur_ch    <= '0;
      res_data  <= '0;
      res_ch    <= '0;
      res_valid <= 1'b0;
      scan_done <= 1'b0;
      init_done <= 1'b0;
`ifdef ADC_OVERSAMPLE_EN
      acc       <= '0;
      os_cnt    <= '0;
`endif
    end else begin
      res_valid <= 1'b0;
      scan_done <= 1'b0;
      case (state)
        SPI_RST:  m_tx_data <= RANGE_WORD;
        RNG_WAIT: if (xfer_done) m_tx_data <= CNTRL_WORD;
        CTL_WAIT: if (xfer_done) init_done <= 1'b1;
        IDLE:     if (scan_start) pending <= ch_mask;
        SELECT: begin
          cur_ch    <= sel_ch;
          m_tx_data <= conv_word;
`ifdef ADC_OVERSAMPLE_EN
          acc       <= '0;
          os_cnt    <= '0;
`endif
        end
        XFER_WAIT: if (xfer_done) begin
`ifdef ADC_OVERSAMPLE_EN
          acc    <= acc_sum;
          os_cnt <= os_cnt + 2'd1;
          if (cap_last) begin
            res_data  <= acc_sum[13:2];
            res_ch    <= cur_ch;
            res_valid <= 1'b1;
            scan_done <= ~|pending_clr;
          end
`else
          res_data  <= m_rx_data[11:0];
          res_ch    <= cur_ch;
          res_valid <= 1'b1;
          scan_done <= ~|pending_clr;
`endif
        end
        STORE:    pending <= pending_clr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Bench for adc_scan_scheduler: behavioural SPI master model, event monitor,
// table-driven scan vectors and directed multi-cycle corner sequences.
module tb_adc_scan_scheduler;
  localparam int PERIOD = 1000;
`ifdef ADC_OVERSAMPLE_EN
  localparam int OS = 4;
`else
  localparam int OS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        overrun_clr = 1'b0;
  logic [3:0]  ch_mask = 4'b0;
  logic        m_enable, m_rst_n, m_busy;
  logic [15:0] m_tx_data;
  logic [15:0] m_rx_data = 16'h0;
  logic [11:0] res_data;
  logic [1:0]  res_ch;
  logic        res_valid, scan_done, init_done, overrun;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adc_scan_scheduler #(.PERIOD(PERIOD)) dut (
    .clk(clk), .rst(rst), .run(run), .ch_mask(ch_mask), .overrun_clr(overrun_clr),
    .m_enable(m_enable), .m_rst_n(m_rst_n), .m_busy(m_busy), .m_tx_data(m_tx_data),
    .m_rx_data(m_rx_data), .res_data(res_data), .res_ch(res_ch), .res_valid(res_valid),
    .scan_done(scan_done), .init_done(init_done), .overrun(overrun)
  );

  // SPI master model: busy for xfer_len cycles after each start pulse.
  int          busy_cnt = 0;
  int          xfer_len = 3;
  int          conv_cnt = 0;
  int          rx_base  = 0;
  logic [15:0] rx_tab [16];

  function automatic logic [15:0] rx_word(input int n);
    return rx_tab[(n / OS) % 16] + 16'(n % OS);
  endfunction

  always @(posedge clk) begin
    if (!m_rst_n) busy_cnt <= 0;
    else if (m_enable) begin
      busy_cnt <= xfer_len;
      if (init_done) begin
        m_rx_data <= rx_word(conv_cnt - rx_base);
        conv_cnt  <= conv_cnt + 1;
      end else m_rx_data <= 16'h0;
    end else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
  end
  assign m_busy = (busy_cnt != 0);

  // Monitor: logs start pulses, results, scan ends and scan start cycles.
  int          cyc = 0;
  logic [15:0] en_tx [64];
  logic [1:0]  r_ch  [64];
  logic [11:0] r_dat [64];
  int          start_cyc [64];
  int          en_n = 0, res_n = 0, done_n = 0, start_n = 0;
  logic        armed = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_enable) begin
      en_tx[en_n % 64] <= m_tx_data;
      en_n <= en_n + 1;
      if (init_done && armed) begin
        start_cyc[start_n % 64] <= cyc;
        start_n <= start_n + 1;
        armed <= 1'b0;
      end
    end
    if (res_valid) begin
      r_ch[res_n % 64]  <= res_ch;
      r_dat[res_n % 64] <= res_data;
      res_n <= res_n + 1;
    end
    if (scan_done) begin
      done_n <= done_n + 1;
      armed  <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int ev_val(input int sel);
    case (sel)
      0: return done_n;
      1: return start_n;
      2: return res_n;
      default: return int'(init_done);
    endcase
  endfunction

  // Bounded wait for a monitor counter to move away from base.
  task automatic wait_ev(input int sel, input int base, input int budget, input string nm);
    int k = 0;
    while (ev_val(sel) == base && k < budget) begin
      @(negedge clk);
      k++;
    end
    checks++;
    if (ev_val(sel) == base) begin
      errors++;
      $display("FAIL %s: no event within %0d cycles", nm, budget);
    end
  endtask

  // Averaging model for one channel's result.
  function automatic logic [11:0] exp_dat(input logic [15:0] w);
    logic [13:0] s = '0;
    logic [15:0] t;
    for (int k = 0; k < OS; k++) begin
      t = w + 16'(k);
      s = s + {2'b00, t[11:0]};
    end
    return (OS == 4) ? s[13:2] : s[11:0];
  endfunction

  typedef struct {
    logic [3:0]       mask;
    logic [3:0][15:0] rx;
    int               n;
    logic [3:0][1:0]  ch;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] m, input logic [15:0] a, b, c, d,
                              input int n, input logic [1:0] c0, c1, c2, c3);
    vec_t v;
    v.mask = m;
    v.rx[0] = a; v.rx[1] = b; v.rx[2] = c; v.rx[3] = d;
    v.n = n;
    v.ch[0] = c0; v.ch[1] = c1; v.ch[2] = c2; v.ch[3] = c3;
    return v;
  endfunction

  vec_t tab [5];

  initial begin
    int eb, rb, db, sb, c0;
    tab[0] = mk(4'b1010, 16'h0123, 16'h0456, 16'h0, 16'h0, 2, 2'd1, 2'd3, 2'd0, 2'd0);
    tab[1] = mk(4'b0001, 16'h0ABC, 16'h0, 16'h0, 16'h0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
    tab[2] = mk(4'b1111, 16'h0001, 16'h0FFF, 16'h0800, 16'h07FF, 4, 2'd0, 2'd1, 2'd2, 2'd3);
    tab[3] = mk(4'b0110, 16'hF234, 16'h5A5A, 16'h0, 16'h0, 2, 2'd1, 2'd2, 2'd0, 2'd0);
    tab[4] = mk(4'b0001, 16'd100, 16'h0, 16'h0, 16'h0, 1, 2'd0, 2'd0, 2'd0, 2'd0);
    for (int i = 0; i < 16; i++) rx_tab[i] = 16'h0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_m_rst_n", 32'(m_rst_n), 0);
    chk("rst_m_enable", 32'(m_enable), 0);
    chk("rst_tx", 32'(m_tx_data), 0);
    chk("rst_init_done", 32'(init_done), 0);
    chk("rst_outputs", {28'(0), res_valid, scan_done, overrun, |res_data}, 0);

    // Init sequence
    eb = en_n;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("spi_rst_low", 32'(m_rst_n), 0);
    @(negedge clk);
    chk("spi_rst_high", 32'(m_rst_n), 1);
    chk("init_rng_en", 32'(m_enable), 1);
    chk("init_rng_tx", 32'(m_tx_data), 32'hD555);
    wait_ev(3, 0, 60, "init_done_wait");
    chk("init_en_count", en_n - eb, 2);
    chk("init_tx0", 32'(en_tx[eb % 64]), 32'hD555);
    chk("init_tx1", 32'(en_tx[(eb + 1) % 64]), 32'h8310);

    // Table-driven scans
    run = 1'b1;
    sb = start_n;
    for (int i = 0; i < 5; i++) begin
      ch_mask = tab[i].mask;
      for (int j = 0; j < 4; j++) rx_tab[j] = tab[i].rx[j];
      rx_base = conv_cnt;
      rb = res_n;
      db = done_n;
      wait_ev(0, db, 1500, "scan_done_wait");
      chk("scan_res_count", res_n - rb, tab[i].n);
      chk("scan_done_count", done_n - db, 1);
      for (int j = 0; j < tab[i].n; j++) begin
        chk("scan_res_ch", 32'(r_ch[(rb + j) % 64]), 32'(tab[i].ch[j]));
        chk("scan_res_data", 32'(r_dat[(rb + j) % 64]), 32'(exp_dat(tab[i].rx[j])));
      end
    end
    chk("scan_period_0", start_cyc[sb % 64] - start_cyc[sb % 64] + start_cyc[(sb + 1) % 64] - start_cyc[sb % 64], PERIOD);
    chk("scan_period_1", start_cyc[(sb + 2) % 64] - start_cyc[(sb + 1) % 64], PERIOD);
    chk("overrun_quiet", 32'(overrun), 0);

    // Overrun: a long transfer swallows a tick; mid-scan mask change ignored
    ch_mask = 4'b0001;
    rx_tab[0] = 16'h0111;
    rx_base = conv_cnt;
    xfer_len = 1200;
    sb = start_n; rb = res_n; db = done_n;
    wait_ev(1, sb, 1500, "ovr_start_wait");
    xfer_len = 3;
    ch_mask = 4'b1111;
    wait_ev(0, db, 1500, "ovr_done_wait");
    ch_mask = 4'b0000;
    chk("ovr_flag", 32'(overrun), 1);
    chk("ovr_res_count", res_n - rb, 1);
    chk("ovr_res_data", 32'(r_dat[rb % 64]), 32'(exp_dat(16'h0111)));
    chk("ovr_scan_count", start_n - sb, 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 0);

    // Tick with empty mask: nothing happens
    eb = en_n; db = done_n;
    repeat (1200) @(negedge clk);
    chk("mask0_no_enable", en_n - eb, 0);
    chk("mask0_no_done", done_n - db, 0);
    chk("mask0_no_overrun", 32'(overrun), 0);

    // run dropped mid-scan: scan finishes, then nothing until run returns
    ch_mask = 4'b1111;
    xfer_len = 20;
    rx_base = conv_cnt;
    rb = res_n; db = done_n;
    wait_ev(2, rb, 1500, "run_first_res");
    run = 1'b0;
    wait_ev(0, db, 500, "run_done_wait");
    chk("run_drop_res_count", res_n - rb, 4);
    eb = en_n;
    repeat (1100) @(negedge clk);
    chk("run_drop_idle", en_n - eb, 0);
    xfer_len = 50;
    sb = start_n;
    @(posedge clk); #1 run = 1'b1;
    c0 = cyc;
    wait_ev(1, sb, 1500, "restart_wait");
    chk("restart_latency", start_cyc[sb % 64] - c0, PERIOD + 1);

    // Reset during XFER_WAIT: immediate reset, init replays
    @(negedge clk);
    chk("xfer_busy", 32'(m_busy), 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_m_rst_n", 32'(m_rst_n), 0);
    chk("mid_rst_tx", 32'(m_tx_data), 0);
    chk("mid_rst_flags", {28'(0), init_done, res_valid, scan_done, m_enable}, 0);
    eb = en_n;
    xfer_len = 3;
    @(posedge clk); #1 rst = 1'b0;
    wait_ev(3, 0, 60, "reinit_wait");
    chk("reinit_en_count", en_n - eb, 2);
    chk("reinit_tx0", 32'(en_tx[eb % 64]), 32'hD555);
    chk("reinit_tx1", 32'(en_tx[(eb + 1) % 64]), 32'h8310);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
